// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Upstream stage of a MAX_DIM x MAX_DIM systolic multiplier array. Holds
//   operand matrices A and B (written one row word per cycle while idle) and,
//   on go, streams diagonally skewed wavefronts onto the array's west/north
//   edge buses. After the wavefronts it drives zeros and waits for the
//   array's done flag, then pulses done_o and returns to idle.
//
// Optional build macro:
//   SYSTOLIC_FEEDER_B_COLMAJOR_EN - a B write with index c stores element k
//   at B[k][c] (host writes B by columns). Undefined: B is row-major like A.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     synchronous reset, active HIGH despite the name
//   wr_en_i    write one stored row/column this cycle
//   wr_sel_i   0 = matrix A, 1 = matrix B
//   wr_idx_i   row (or B column) index
//   wr_data_i  element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   go_i       start request (honoured only when idle)
//   done_i     array done flag (honoured only while waiting)
//   west_o     row i in slice MAX_DIM-1-i
//   north_o    column j in slice MAX_DIM-1-j
//   start_o    array start, high in the first feed cycle
//   busy_o     high while feeding or waiting for the array
//   done_o     one-cycle completion pulse
//   wr_err_o   one-cycle pulse for a rejected write
module systolic_feeder #(
    parameter  int BUS_WIDTH  = 32,
    parameter  int DATA_WIDTH = 8,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_en_i,
    input  logic                          wr_sel_i,
    input  logic [IDX_W-1:0]              wr_idx_i,
    input  logic [BUS_WIDTH-1:0]          wr_data_i,
    input  logic                          go_i,
    input  logic                          done_i,
    output logic [MAX_DIM*DATA_WIDTH-1:0] west_o,
    output logic [MAX_DIM*DATA_WIDTH-1:0] north_o,
    output logic                          start_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          wr_err_o
);

    localparam int LAST_T = 2 * MAX_DIM - 2;
    localparam int T_W    = (2 * MAX_DIM - 1 > 1) ? $clog2(2 * MAX_DIM - 1) : 1;

    typedef enum logic [1:0] {IDLE, FEED, WAIT_DONE} state_e;
    typedef logic [MAX_DIM-1:0][DATA_WIDTH-1:0] row_t;
    typedef row_t [MAX_DIM-1:0]                 mat_t;

    state_e         state_q, state_d;
    logic [T_W-1:0] t_q, t_d;
    mat_t           a_q, a_d, b_q, b_d;
    row_t           west_q, west_d, north_q, north_d;
    row_t           wr_row;
    logic           start_q, start_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           wr_err_q, wr_err_d;
    logic           idx_hit;

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = 1'b0;
        wr_err_d = 1'b0;
        idx_hit  = 1'b0;
        wr_row   = wr_data_i[MAX_DIM*DATA_WIDTH-1:0];

        case (state_q)
            IDLE: begin
                // Store update happens before the feed uses a_d/b_d, so a
                // write alongside go is visible from the first wavefront.
                if (wr_en_i) begin
                    for (int r = 0; r < MAX_DIM; r++) begin
                        if (wr_idx_i == IDX_W'(r)) begin
                            idx_hit = 1'b1;
                            if (!wr_sel_i) begin
                                a_d[r] = wr_row;
                            end else begin
`ifdef SYSTOLIC_FEEDER_B_COLMAJOR_EN
                                for (int k = 0; k < MAX_DIM; k++)
                                    b_d[k][r] = wr_row[k];
`else
                                b_d[r] = wr_row;
`endif
                            end
                        end
                    end
                    wr_err_d = !idx_hit;
                end
                if (go_i) begin
                    state_d = FEED;
                    t_d     = '0;
                end
            end
            FEED: begin
                wr_err_d = wr_en_i;
                if (t_q == T_W'(LAST_T)) begin
                    state_d = WAIT_DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                wr_err_d = wr_en_i;
                if (done_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with
        // the state they describe. Row i carries A[i][t-i], column j B[t-j][j].
        west_d  = '0;
        north_d = '0;
        if (state_d == FEED) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int k = 0; k < MAX_DIM; k++) begin
                    if (t_d == T_W'(i + k)) begin
                        west_d[MAX_DIM-1-i]  = a_d[i][k];
                        north_d[MAX_DIM-1-i] = b_d[k][i];
                    end
                end
            end
        end
        start_d = (state_d == FEED) && (t_d == '0);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state_q  <= IDLE;
            t_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            west_q   <= '0;
            north_q  <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            a_q      <= a_d;
            b_q      <= b_d;
            west_q   <= west_d;
            north_q  <= north_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign west_o   = west_q;
    assign north_o  = north_q;
    assign start_o  = start_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign wr_err_o = wr_err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;
    localparam int D  = 4;
    localparam int DW = 8;
    localparam int NT = 2 * D - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, wr_sel, go, done_in;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data, west, north;
    logic        start, busy, done_out, wr_err;

    // Second instance with a non-power-of-two dimension so an index can be
    // out of range (MAX_DIM=3, index width 2).
    logic        s_wr_en;
    logic [1:0]  s_idx;
    logic [23:0] s_data, s_west, s_north;
    logic        s_start, s_busy, s_done, s_err;

    systolic_feeder dut (
        .clk_i(clk), .rst_ni(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_idx_i(wr_idx), .wr_data_i(wr_data), .go_i(go), .done_i(done_in),
        .west_o(west), .north_o(north), .start_o(start), .busy_o(busy),
        .done_o(done_out), .wr_err_o(wr_err)
    );

    systolic_feeder #(.BUS_WIDTH(24), .DATA_WIDTH(8)) dut3 (
        .clk_i(clk), .rst_ni(rst), .wr_en_i(s_wr_en), .wr_sel_i(1'b0),
        .wr_idx_i(s_idx), .wr_data_i(s_data), .go_i(1'b0), .done_i(1'b0),
        .west_o(s_west), .north_o(s_north), .start_o(s_start), .busy_o(s_busy),
        .done_o(s_done), .wr_err_o(s_err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] ra [D][D];
    logic [7:0] rb [D][D];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < D; i++)
            for (int k = 0; k < D; k++) begin
                ra[i][k] = 8'h00;
                rb[i][k] = 8'h00;
            end
    endtask

    task automatic mdl_wr(input bit sel, input int idx, input logic [31:0] d);
        for (int k = 0; k < D; k++) begin
            if (!sel) ra[idx][k] = d[k*DW +: DW];
`ifdef SYSTOLIC_FEEDER_B_COLMAJOR_EN
            else      rb[k][idx] = d[k*DW +: DW];
`else
            else      rb[idx][k] = d[k*DW +: DW];
`endif
        end
    endtask

    // Wavefront at step t: row i sees A[i][t-i], column j sees B[t-j][j].
    function automatic logic [31:0] exp_west(input int t);
        logic [31:0] r = '0;
        for (int i = 0; i < D; i++)
            if (t - i >= 0 && t - i < D) r[(D-1-i)*DW +: DW] = ra[i][t-i];
        return r;
    endfunction

    function automatic logic [31:0] exp_north(input int t);
        logic [31:0] r = '0;
        for (int j = 0; j < D; j++)
            if (t - j >= 0 && t - j < D) r[(D-1-j)*DW +: DW] = rb[t-j][j];
        return r;
    endfunction

    task automatic wr(input bit sel, input int idx, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_idx = idx[1:0]; wr_data = d;
        step();
        wr_en = 1'b0;
        mdl_wr(sel, idx, d);
        chk("wr_err_inrange", wr_err, 0);
    endtask

    // lit: 1 = skew literal checks, 2 = column-0 literal checks
    task automatic run(input bit gw, input bit gsel, input int gidx,
                       input logic [31:0] gd, input bit poke, input int lit);
        go = 1'b1;
        if (gw) begin
            wr_en = 1'b1; wr_sel = gsel; wr_idx = gidx[1:0]; wr_data = gd;
        end
        step();
        go = 1'b0; wr_en = 1'b0;
        if (gw) mdl_wr(gsel, gidx, gd);
        for (int t = 0; t < NT; t++) begin
            chk("west", west, exp_west(t));
            chk("north", north, exp_north(t));
            chk("start", start, (t == 0));
            chk("busy_feed", busy, 1);
            chk("done_feed", done_out, 0);
            chk("wr_err_feed", wr_err, (poke && t == 2));
            if (lit == 1) begin
                if (t == 0) begin
                    chk("skew_t0_w", west, 32'h01000000);
                    chk("skew_t0_n", north, 32'h01000000);
                end
                if (t == 1) begin
                    chk("skew_t1_w", west, 32'h02050000);
                    chk("skew_t1_n", north, 32'h00000000);
                end
                if (t == 3) chk("skew_t3_w", west, 32'h04070A0D);
                if (t == 6) begin
                    chk("skew_t6_w", west, 32'h00000010);
                    chk("skew_t6_n", north, 32'h00000001);
                end
            end
`ifdef SYSTOLIC_FEEDER_B_COLMAJOR_EN
            if (lit == 2 && t < 4) chk("colmaj_n0", north[31:24], t + 1);
`endif
            // A write and a done flag during FEED must both be ignored.
            done_in = poke && (t == 1);
            wr_en   = poke && (t == 1);
            wr_sel  = 1'b0; wr_idx = 2'd0; wr_data = $urandom;
            step();
            done_in = 1'b0; wr_en = 1'b0;
        end
        for (int w = 0; w < 10; w++) begin
            chk("west_wait", west, 0);
            chk("north_wait", north, 0);
            chk("busy_wait", busy, 1);
            chk("done_wait", done_out, 0);
            step();
        end
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        chk("done_pulse", done_out, 1);
        chk("busy_after_done", busy, 0);
        step();
        chk("done_single", done_out, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_idx = '0; wr_data = '0;
        go = 1'b0; done_in = 1'b0; s_wr_en = 1'b0; s_idx = '0; s_data = '0;
        mdl_clear();
        step(); step();
        rst = 1'b0;
        chk("rst_west", west, 0);
        chk("rst_north", north, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_out, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_s_out", {s_west[7:0], s_north[7:0], s_start, s_busy, s_done, s_err}, 0);

        // Empty stores stream zeros
        run(0, 0, 0, 0, 0, 0);

        // Skew check with A[i][k]=4i+k+1, B=identity, plus ignored FEED write/done
        for (int i = 0; i < D; i++) begin
            for (int k = 0; k < D; k++) d[k*DW +: DW] = 8'(4 * i + k + 1);
            wr(0, i, d);
        end
        for (int i = 0; i < D; i++) wr(1, i, 32'h1 << (i * DW));
        run(0, 0, 0, 0, 1, 1);
        // Same operands again: rejected write left the stores unchanged
        run(0, 0, 0, 0, 0, 1);

        // Random operands, one row written alongside go, then a re-run
        repeat (3) begin
            for (int r = 0; r < D; r++) begin
                wr(0, r, $urandom);
                wr(1, r, $urandom);
            end
            run(1, 1'($urandom_range(1)), $urandom_range(D - 1), $urandom, 0, 0);
            run(0, 0, 0, 0, 0, 0);
        end

        // Reset at t=3 aborts and clears; a go right after release restarts
        go = 1'b1;
        step();
        go = 1'b0;
        step(); step(); step();
        chk("pre_rst_t3", west, exp_west(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        mdl_clear();
        chk("midrst_west", west, 0);
        chk("midrst_north", north, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", start, 0);
        run(0, 0, 0, 0, 0, 0);

        // B column/row 0 write
        wr(1, 0, 32'h04030201);
        run(0, 0, 0, 0, 0, 2);

        // Out-of-range index on the MAX_DIM=3 instance
        s_wr_en = 1'b1; s_idx = 2'd3; s_data = 24'($urandom);
        step();
        s_wr_en = 1'b0;
        chk("oor_err", s_err, 1);
        step();
        chk("oor_err_single", s_err, 0);
        s_wr_en = 1'b1; s_idx = 2'd2;
        step();
        s_wr_en = 1'b0;
        chk("inrange_err", s_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
